// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares one memory/IO bus between the MFU load/store
// port (d_*) and instruction fetch (f_*). Reads are tagged in an in-order
// FIFO so each response is steered back to fetch or onto the CDB.
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN (alternate grants on contention).

package fcpu_pkg;
    localparam int DATA_W   = 32;
    localparam int RSV_ID_W = 4;
    localparam int INSTR_W  = 6;

    localparam logic [INSTR_W-1:0] I_NOP     = 6'h00;
    localparam logic [INSTR_W-1:0] I_LOAD    = 6'h01;
    localparam logic [INSTR_W-1:0] I_LOADB   = 6'h02;
    localparam logic [INSTR_W-1:0] I_LOADR   = 6'h03;
    localparam logic [INSTR_W-1:0] I_LOADT   = 6'h04;
    localparam logic [INSTR_W-1:0] I_LOADTB  = 6'h05;
    localparam logic [INSTR_W-1:0] I_INPUT   = 6'h06;
    localparam logic [INSTR_W-1:0] I_STORE   = 6'h08;
    localparam logic [INSTR_W-1:0] I_STOREB  = 6'h09;
    localparam logic [INSTR_W-1:0] I_STORER  = 6'h0A;
    localparam logic [INSTR_W-1:0] I_STORET  = 6'h0B;
    localparam logic [INSTR_W-1:0] I_STORETB = 6'h0C;
    localparam logic [INSTR_W-1:0] I_OUTPUT  = 6'h0D;
    localparam logic [INSTR_W-1:0] I_ADD     = 6'h10;
endpackage

module memory_port_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int DATA_W          = fcpu_pkg::DATA_W,
    parameter int RSV_ID_W        = fcpu_pkg::RSV_ID_W,
    parameter int INSTR_W         = fcpu_pkg::INSTR_W
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         d_valid,
    input  logic [INSTR_W-1:0]           d_opcode,
    input  logic [RSV_ID_W-1:0]          d_rsv_id,
    input  logic [DATA_W-1:0]            d_address,
    input  logic [DATA_W-1:0]            d_data,
    output logic                         d_ready,
    input  logic                         f_valid,
    input  logic [DATA_W-1:0]            f_address,
    output logic                         f_ready,
    output logic                         f_rvalid,
    output logic [DATA_W-1:0]            f_rdata,
    input  logic                         f_rready,
    output logic [RSV_ID_W+DATA_W-1:0]   o_cdb,
    output logic                         o_cdb_valid,
    input  logic                         o_cdb_ready,
    output logic                         m_valid,
    output logic                         m_we,
    output logic                         m_io,
    output logic [DATA_W-1:0]            m_address,
    output logic [DATA_W-1:0]            m_wdata,
    input  logic                         m_ready,
    input  logic                         m_rvalid,
    input  logic [DATA_W-1:0]            m_rdata,
    output logic                         m_rready
);

    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;

    function automatic logic op_is_read(input logic [INSTR_W-1:0] op);
        case (op)
            fcpu_pkg::I_LOAD, fcpu_pkg::I_LOADB, fcpu_pkg::I_LOADR,
            fcpu_pkg::I_LOADT, fcpu_pkg::I_LOADTB, fcpu_pkg::I_INPUT: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic op_is_write(input logic [INSTR_W-1:0] op);
        case (op)
            fcpu_pkg::I_STORE, fcpu_pkg::I_STOREB, fcpu_pkg::I_STORER,
            fcpu_pkg::I_STORET, fcpu_pkg::I_STORETB, fcpu_pkg::I_OUTPUT: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Extended pointers: the extra MSB distinguishes full from empty.
    logic [CW-1:0]       head_q, head_d, tail_q, tail_d, count;
    logic [PW-1:0]       head_idx, tail_idx;
    logic                tag_src_q [MAX_OUTSTANDING];
    logic                tag_src_d [MAX_OUTSTANDING];
    logic [RSV_ID_W-1:0] tag_id_q  [MAX_OUTSTANDING];
    logic [RSV_ID_W-1:0] tag_id_d  [MAX_OUTSTANDING];

    logic full, empty;
    logic d_rd, d_wr, d_drop, d_elig, f_elig;
    logic gnt_d, gnt_f;
    logic push, pop, push_src;
    logic [RSV_ID_W-1:0] push_id;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // 0 = data was granted last, 1 = fetch was granted last
    logic last_q, last_d;
`endif

    // Arbitration, command drive, response steering and FIFO next state
    always_comb begin
        count    = tail_q - head_q;
        head_idx = head_q[PW-1:0];
        tail_idx = tail_q[PW-1:0];
        full     = (count == CW'(MAX_OUTSTANDING));
        empty    = (count == '0);

        d_rd   = d_valid && op_is_read(d_opcode);
        d_wr   = d_valid && op_is_write(d_opcode);
        d_drop = d_valid && !d_rd && !d_wr;
        // Eligibility looks only at the registered count, so a pop this
        // cycle frees a read slot next cycle.
        d_elig = d_wr || (d_rd && !full);
        f_elig = f_valid && !full;

`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (d_elig && f_elig) begin
            gnt_d = last_q;
            gnt_f = !last_q;
        end else begin
            gnt_d = d_elig;
            gnt_f = f_elig;
        end
`else
        gnt_d = d_elig;
        gnt_f = f_elig && !d_elig;
`endif

        m_valid   = gnt_d || gnt_f;
        m_we      = gnt_d && d_wr;
        m_io      = gnt_d && (d_opcode == fcpu_pkg::I_INPUT || d_opcode == fcpu_pkg::I_OUTPUT);
        m_address = gnt_d ? d_address : (gnt_f ? f_address : '0);
        m_wdata   = gnt_d ? d_data : '0;
        // Unknown opcodes are swallowed without touching the bus.
        d_ready   = d_drop || (gnt_d && m_ready);
        f_ready   = gnt_f && m_ready;

        push     = m_ready && ((gnt_d && d_rd) || gnt_f);
        push_src = gnt_d;
        push_id  = gnt_d ? d_rsv_id : '0;

        f_rvalid    = 1'b0;
        f_rdata     = '0;
        o_cdb       = '0;
        o_cdb_valid = 1'b0;
        m_rready    = 1'b0;
        // With no tag outstanding a response is a protocol error: ignore it.
        if (!empty) begin
            if (tag_src_q[head_idx]) begin
                o_cdb       = {tag_id_q[head_idx], m_rdata};
                o_cdb_valid = m_rvalid;
                m_rready    = o_cdb_ready;
            end else begin
                f_rvalid = m_rvalid;
                f_rdata  = m_rdata;
                m_rready = f_rready;
            end
        end
        pop = m_rvalid && m_rready;

        // Outputs are forced quiet while reset is held.
        if (!nrst) begin
            m_valid     = 1'b0;
            m_we        = 1'b0;
            m_io        = 1'b0;
            m_address   = '0;
            m_wdata     = '0;
            d_ready     = 1'b0;
            f_ready     = 1'b0;
            f_rvalid    = 1'b0;
            f_rdata     = '0;
            o_cdb       = '0;
            o_cdb_valid = 1'b0;
            m_rready    = 1'b0;
            push        = 1'b0;
            pop         = 1'b0;
        end

        head_d    = head_q + {{PW{1'b0}}, pop};
        tail_d    = tail_q + {{PW{1'b0}}, push};
        tag_src_d = tag_src_q;
        tag_id_d  = tag_id_q;
        if (push) begin
            tag_src_d[tail_idx] = push_src;
            tag_id_d[tail_idx]  = push_id;
        end

`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_d = last_q;
        if (m_valid && m_ready) last_d = gnt_f;
`endif
    end

    // Tag FIFO and grant-history state
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            head_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                tag_src_q[i] <= 1'b0;
                tag_id_q[i]  <= '0;
            end
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q <= 1'b0;
`endif
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            tag_src_q <= tag_src_d;
            tag_id_q  <= tag_id_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q    <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter: a table of single-cycle command
// vectors plus hand sequences for load/response routing, full FIFO,
// backpressure with reset, and contention (both arbitration builds).
module tb_memory_port_arbiter;
    import fcpu_pkg::*;

    logic        clk, nrst;
    logic        d_valid;
    logic [5:0]  d_opcode;
    logic [3:0]  d_rsv_id;
    logic [31:0] d_address, d_data;
    logic        d_ready;
    logic        f_valid;
    logic [31:0] f_address;
    logic        f_ready, f_rvalid;
    logic [31:0] f_rdata;
    logic        f_rready;
    logic [35:0] o_cdb;
    logic        o_cdb_valid, o_cdb_ready;
    logic        m_valid, m_we, m_io;
    logic [31:0] m_address, m_wdata;
    logic        m_ready, m_rvalid;
    logic [31:0] m_rdata;
    logic        m_rready;

    int pass_cnt = 0;
    int total_cnt = 0;

    memory_port_arbiter #(.MAX_OUTSTANDING(4)) dut (
        .clk(clk), .nrst(nrst),
        .d_valid(d_valid), .d_opcode(d_opcode), .d_rsv_id(d_rsv_id),
        .d_address(d_address), .d_data(d_data), .d_ready(d_ready),
        .f_valid(f_valid), .f_address(f_address), .f_ready(f_ready),
        .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_rready(f_rready),
        .o_cdb(o_cdb), .o_cdb_valid(o_cdb_valid), .o_cdb_ready(o_cdb_ready),
        .m_valid(m_valid), .m_we(m_we), .m_io(m_io),
        .m_address(m_address), .m_wdata(m_wdata), .m_ready(m_ready),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rready(m_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        dv;
        logic [5:0]  op;
        logic [31:0] da, dd;
        logic        fv;
        logic [31:0] fa;
        logic        mr;
        logic        e_mv, e_we, e_io;
        logic [31:0] e_ma, e_wd;
        logic        e_dr, e_fr;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic idle();
        d_valid = 0; d_opcode = I_NOP; d_rsv_id = 0; d_address = 0; d_data = 0;
        f_valid = 0; f_address = 0; f_rready = 0;
        o_cdb_ready = 0; m_ready = 0; m_rvalid = 0; m_rdata = 0;
    endtask

    // Move to just after the next rising edge, where inputs change.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic d_req(input logic [5:0] op, input logic [3:0] id,
                         input logic [31:0] a, input logic [31:0] dat);
        d_valid = 1; d_opcode = op; d_rsv_id = id; d_address = a; d_data = dat;
    endtask

    task automatic rsp(input logic [31:0] dat);
        m_rvalid = 1; m_rdata = dat;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".m_valid"}, 64'(m_valid), 64'd0);
        chk({tag, ".m_we"}, 64'(m_we), 64'd0);
        chk({tag, ".m_io"}, 64'(m_io), 64'd0);
        chk({tag, ".m_address"}, 64'(m_address), 64'd0);
        chk({tag, ".m_wdata"}, 64'(m_wdata), 64'd0);
        chk({tag, ".d_ready"}, 64'(d_ready), 64'd0);
        chk({tag, ".f_ready"}, 64'(f_ready), 64'd0);
        chk({tag, ".f_rvalid"}, 64'(f_rvalid), 64'd0);
        chk({tag, ".o_cdb_valid"}, 64'(o_cdb_valid), 64'd0);
        chk({tag, ".m_rready"}, 64'(m_rready), 64'd0);
    endtask

    initial begin
        logic gf;
        vecs[0] = '{"store",       1, I_STORE,   32'h100, 32'hDEAD, 0, 32'h0,  1, 1, 1, 0, 32'h100, 32'hDEAD, 1, 0};
        vecs[1] = '{"output",      1, I_OUTPUT,  32'h7,   32'h55,   0, 32'h0,  1, 1, 1, 1, 32'h7,   32'h55,   1, 0};
        vecs[2] = '{"store_stall", 1, I_STOREB,  32'h20,  32'h9,    0, 32'h0,  0, 1, 1, 0, 32'h20,  32'h9,    0, 0};
        vecs[3] = '{"load_stall",  1, I_LOAD,    32'h40,  32'h0,    0, 32'h0,  0, 1, 0, 0, 32'h40,  32'h0,    0, 0};
        vecs[4] = '{"input_stall", 1, I_INPUT,   32'h3,   32'h0,    0, 32'h0,  0, 1, 0, 1, 32'h3,   32'h0,    0, 0};
        vecs[5] = '{"fetch_stall", 0, I_NOP,     32'h0,   32'h0,    1, 32'h80, 0, 1, 0, 0, 32'h80,  32'h0,    0, 0};
        vecs[6] = '{"drop",        1, I_ADD,     32'h60,  32'h1,    0, 32'h0,  1, 0, 0, 0, 32'h0,   32'h0,    1, 0};
        vecs[7] = '{"drop_fetch",  1, I_ADD,     32'h60,  32'h1,    1, 32'h84, 0, 1, 0, 0, 32'h84,  32'h0,    1, 0};
        vecs[8] = '{"idle",        0, I_NOP,     32'h0,   32'h0,    0, 32'h0,  0, 0, 0, 0, 32'h0,   32'h0,    0, 0};
        vecs[9] = '{"storetb",     1, I_STORETB, 32'h30,  32'h7,    0, 32'h0,  1, 1, 1, 0, 32'h30,  32'h7,    1, 0};

        idle();
        nrst = 0;
        #2;
        chk_all_zero("reset");
        step();
        nrst = 1;

        // Single-cycle command vectors; none of them pushes a read tag.
        foreach (vecs[i]) begin
            step();
            idle();
            d_valid = vecs[i].dv; d_opcode = vecs[i].op;
            d_address = vecs[i].da; d_data = vecs[i].dd;
            f_valid = vecs[i].fv; f_address = vecs[i].fa; m_ready = vecs[i].mr;
            #2;
            chk({vecs[i].name, ".m_valid"},   64'(m_valid),   64'(vecs[i].e_mv));
            chk({vecs[i].name, ".m_we"},      64'(m_we),      64'(vecs[i].e_we));
            chk({vecs[i].name, ".m_io"},      64'(m_io),      64'(vecs[i].e_io));
            chk({vecs[i].name, ".m_address"}, 64'(m_address), 64'(vecs[i].e_ma));
            chk({vecs[i].name, ".m_wdata"},   64'(m_wdata),   64'(vecs[i].e_wd));
            chk({vecs[i].name, ".d_ready"},   64'(d_ready),   64'(vecs[i].e_dr));
            chk({vecs[i].name, ".f_ready"},   64'(f_ready),   64'(vecs[i].e_fr));
        end

        // Nothing outstanding: a stray response is refused.
        step(); idle(); rsp(32'hBAD); o_cdb_ready = 1; f_rready = 1; #2;
        chk("stray.m_rready", 64'(m_rready), 64'd0);
        chk("stray.o_cdb_valid", 64'(o_cdb_valid), 64'd0);
        chk("stray.f_rvalid", 64'(f_rvalid), 64'd0);

        // Load forwarded to CDB two cycles after issue
        step(); idle(); d_req(I_LOAD, 4'd5, 32'h40, 32'h0); m_ready = 1; #2;
        chk("load.d_ready", 64'(d_ready), 64'd1);
        chk("load.m_we", 64'(m_we), 64'd0);
        step(); idle();
        step(); idle(); rsp(32'h1234); o_cdb_ready = 1; #2;
        chk("load.o_cdb", 64'(o_cdb), 64'({4'd5, 32'h1234}));
        chk("load.o_cdb_valid", 64'(o_cdb_valid), 64'd1);
        chk("load.f_rvalid", 64'(f_rvalid), 64'd0);
        chk("load.m_rready", 64'(m_rready), 64'd1);

        // Fetch then IO input; responses return in issue order
        step(); idle(); f_valid = 1; f_address = 32'h0; m_ready = 1; #2;
        chk("mix.f_ready", 64'(f_ready), 64'd1);
        step(); idle(); d_req(I_INPUT, 4'd3, 32'h8, 32'h0); m_ready = 1; #2;
        chk("mix.m_io", 64'(m_io), 64'd1);
        chk("mix.d_ready", 64'(d_ready), 64'd1);
        step(); idle(); rsp(32'hAA); f_rready = 1; o_cdb_ready = 1; #2;
        chk("mix.f_rvalid", 64'(f_rvalid), 64'd1);
        chk("mix.f_rdata", 64'(f_rdata), 64'hAA);
        chk("mix.cdb_quiet", 64'(o_cdb_valid), 64'd0);
        step(); idle(); rsp(32'hBB); f_rready = 1; o_cdb_ready = 1; #2;
        chk("mix.o_cdb", 64'(o_cdb), 64'({4'd3, 32'hBB}));
        chk("mix.o_cdb_valid", 64'(o_cdb_valid), 64'd1);
        chk("mix.f_quiet", 64'(f_rvalid), 64'd0);

        // Fill the tag FIFO
        for (int i = 1; i <= 4; i++) begin
            step(); idle(); d_req(I_LOAD, 4'(i), 32'(i * 16), 32'h0); m_ready = 1; #2;
            chk($sformatf("full.fill%0d", i), 64'(d_ready), 64'd1);
        end
        step(); idle(); d_req(I_LOAD, 4'd6, 32'h90, 32'h0); f_valid = 1; f_address = 32'h94; m_ready = 1; #2;
        chk("full.load_blocked", 64'(d_ready), 64'd0);
        chk("full.fetch_blocked", 64'(f_ready), 64'd0);
        chk("full.m_valid", 64'(m_valid), 64'd0);
        step(); idle(); d_req(I_STORE, 4'd0, 32'h44, 32'h66); f_valid = 1; f_address = 32'h94; m_ready = 1; #2;
        chk("full.store_ok", 64'(d_ready), 64'd1);
        chk("full.store_we", 64'(m_we), 64'd1);
        chk("full.store_fetch", 64'(f_ready), 64'd0);
        step(); idle(); d_req(I_LOAD, 4'd6, 32'h90, 32'h0); m_ready = 1; rsp(32'h11); o_cdb_ready = 1; #2;
        chk("full.pop_cdb", 64'(o_cdb), 64'({4'd1, 32'h11}));
        chk("full.same_cycle", 64'(d_ready), 64'd0);
        step(); idle(); d_req(I_LOAD, 4'd6, 32'h90, 32'h0); m_ready = 1; #2;
        chk("full.next_cycle", 64'(d_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            logic [3:0] eid;
            eid = (i == 3) ? 4'd6 : 4'(i + 2);
            step(); idle(); rsp(32'(8'h22 * (i + 1))); o_cdb_ready = 1; #2;
            chk($sformatf("full.drain%0d", i), 64'(o_cdb), 64'({eid, 32'(8'h22 * (i + 1))}));
        end

        // Backpressured response then reset mid-stall
        step(); idle(); d_req(I_LOAD, 4'd7, 32'h50, 32'h0); m_ready = 1; #2;
        chk("bp.issue", 64'(d_ready), 64'd1);
        step(); idle();
        for (int i = 0; i < 3; i++) begin
            step(); idle(); rsp(32'h77); #2;
            chk($sformatf("bp.m_rready%0d", i), 64'(m_rready), 64'd0);
            chk($sformatf("bp.held%0d", i), 64'({o_cdb_valid, o_cdb}), 64'({1'b1, 4'd7, 32'h77}));
        end
        step(); idle(); rsp(32'h77); d_req(I_STORE, 4'd0, 32'h10, 32'h1); f_valid = 1; m_ready = 1;
        #1; nrst = 0; #1;
        chk_all_zero("rst_mid");
        step(); nrst = 1; idle(); rsp(32'h77); o_cdb_ready = 1; f_rready = 1; #2;
        chk("post_rst.m_rready", 64'(m_rready), 64'd0);
        chk("post_rst.o_cdb_valid", 64'(o_cdb_valid), 64'd0);
        chk("post_rst.f_rvalid", 64'(f_rvalid), 64'd0);

        // Contention with fresh grant history
        for (int i = 0; i < 4; i++) begin
            step(); idle(); d_req(I_STORE, 4'd0, 32'h200, 32'h5);
            f_valid = 1; f_address = 32'h300; m_ready = 1; #2;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            gf = (i % 2 == 0);
`else
            gf = 1'b0;
`endif
            chk($sformatf("cont%0d.f_ready", i), 64'(f_ready), 64'(gf));
            chk($sformatf("cont%0d.d_ready", i), 64'(d_ready), 64'(!gf));
            chk($sformatf("cont%0d.m_address", i), 64'(m_address), gf ? 64'h300 : 64'h200);
        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
        for (int i = 0; i < 2; i++) begin
            step(); idle(); rsp(32'hF0 + 32'(i)); f_rready = 1; #2;
            chk($sformatf("cont.fresp%0d", i), 64'({f_rvalid, f_rdata}), 64'({1'b1, 32'hF0 + 32'(i)}));
        end
`endif
        step(); idle(); rsp(32'h1); f_rready = 1; o_cdb_ready = 1; #2;
        chk("cont.empty", 64'(m_rready), 64'd0);

        step(); idle();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/memory_port_arbiter.md
Name: memory_port_arbiter

Overview:
- Shares the single external memory/IO bus between two requesters: the memory functional unit's load/store issue port (d_*) and the instruction-fetch port (f_*).
- Translates MFU opcodes into bus read/write commands.
- Tracks outstanding reads in an in-order tag FIFO and routes each read response either back to fetch or onto the MFU's CDB as {rsv_id, data}.
- Sits between memory_functional_unit (o_valid/o_opcode/o_rsv_id/o_address/o_data/o_ready) and the memory/IO subsystem.

Parameters:
- MAX_OUTSTANDING, 4, depth of the in-order read-tag FIFO; power of two, minimum 2.
- DATA_W, fcpu_pkg DATA_W, address/data width.
- RSV_ID_W, fcpu_pkg RSV_ID_W, reservation/ROB id width.
- INSTR_W, fcpu_pkg INSTR_W, opcode width.

Ports:
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- d_valid  in  1  MFU request valid
- d_opcode  in  INSTR_W  MFU opcode
- d_rsv_id  in  RSV_ID_W  MFU rob id
- d_address  in  DATA_W  MFU address
- d_data  in  DATA_W  MFU store data
- d_ready  out  1  MFU request accepted
- f_valid  in  1  fetch request valid
- f_address  in  DATA_W  fetch address
- f_ready  out  1  fetch request accepted
- f_rvalid  out  1  fetch response valid
- f_rdata  out  DATA_W  fetch response data
- f_rready  in  1  fetch response accepted
- o_cdb  out  RSV_ID_W+DATA_W  load result {rsv_id, data}
- o_cdb_valid  out  1  load result valid
- o_cdb_ready  in  1  CDB accepted
- m_valid  out  1  bus command valid
- m_we  out  1  1 = write
- m_io  out  1  1 = IO space (I_INPUT/I_OUTPUT)
- m_address  out  DATA_W  bus address
- m_wdata  out  DATA_W  bus write data
- m_ready  in  1  bus command accepted
- m_rvalid  in  1  bus read data valid (reads only, in order)
- m_rdata  in  DATA_W  bus read data
- m_rready  out  1  read data accepted

Behaviour:
- Reset: nrst low asynchronously clears the tag FIFO (head = tail = count = 0), the grant-pointer register and all state. All outputs are 0 while in reset, except f_rdata, o_cdb, m_address and m_wdata, which are don't-care but driven 0.
- Opcode classes:
  - Read: I_LOAD, I_LOADB, I_LOADR, I_LOADT, I_LOADTB, I_INPUT.
  - Write: I_STORE, I_STOREB, I_STORER, I_STORET, I_STORETB, I_OUTPUT.
  - Any other opcode with d_valid: d_ready = 1 for one cycle and the request is consumed with no bus command (drop).
- Arbitration (combinational, same cycle):
  - Candidates are d_valid and f_valid.
  - A read candidate is eligible only when the registered count < MAX_OUTSTANDING. Writes are always eligible.
  - Fixed priority: data > fetch.
- Command drive: the granted request drives m_valid/m_we/m_io/m_address/m_wdata. Fetch uses m_we = 0, m_io = 0, m_wdata = 0.
- Command handshake: d_ready or f_ready equals (granted and m_ready); there is zero-cycle pass-through, with no command register. The non-granted requester's ready is 0.
- Tag push: on an accepted read, push {src, rsv_id} into the tag FIFO at the clock edge. src = 0 for fetch, 1 for data; fetch pushes rsv_id = 0.
- Response routing by head tag src:
  - src = 1: o_cdb = {head.rsv_id, m_rdata}, o_cdb_valid = m_rvalid, m_rready = o_cdb_ready.
  - src = 0: f_rvalid = m_rvalid, f_rdata = m_rdata, m_rready = f_rready.
  - The other response output is 0.
- Tag pop: on m_rvalid && m_rready.
- m_rvalid with an empty FIFO is a protocol error: m_rready = 0 and no output is asserted.
- Pointers wrap modulo MAX_OUTSTANDING. count = tail − head in a width of log2(MAX_OUTSTANDING)+1 bits.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full: eligibility uses the registered count only, so a pop in the same cycle does not open a read slot until the next cycle. Writes still proceed when full.
- Latency: command is 0 cycles (combinational). Response routing is 0 cycles.
- Ordering: the bus returns reads in issue order. Writes generate no response.
- Reset mid-operation discards all outstanding tags. Later m_rvalid is treated as the error case above.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last-grant register, reset 0 meaning "data last".
  - When both requesters are eligible, grant the one not granted last.
  - The register updates only on an accepted command.
  - A single eligible requester is always granted.
- Undefined: fixed priority data > fetch; the register is absent.

Test Plan:
- Store: d_valid, I_STORE, address 0x100, data 0xDEAD, m_ready = 1 → same cycle m_valid = 1, m_we = 1, m_address = 0x100, m_wdata = 0xDEAD, d_ready = 1; count stays 0.
- Load forward:
  - d I_LOAD rsv_id 5, address 0x40 accepted.
  - m_rvalid 2 cycles later with rdata 0x1234 and o_cdb_ready = 1 → o_cdb = {5, 0x1234}, o_cdb_valid = 1, f_rvalid = 0.
- Mixed order: fetch read 0x0, then d I_INPUT rsv_id 3 (m_io = 1), responses 0xAA then 0xBB → f_rdata = 0xAA first, then o_cdb = {3, 0xBB}.
- Full: 4 loads accepted with no responses → 5th load d_ready = 0, while a concurrent I_STORE is accepted. One response returned → the load is accepted the following cycle, not the same cycle.
- Contention: d_valid and f_valid held for 4 cycles, m_ready = 1.
  - Without the macro → d granted all 4 cycles, f_ready = 0.
  - With MEM_ARB_ROUND_ROBIN_EN → grants alternate f, d, f, d (first grant goes to f, since the register resets to "data last").
- Backpressure and reset: a response with o_cdb_ready = 0 is held for 3 cycles → m_rready = 0 and the tag is not popped. Then nrst pulses low mid-stall → all outputs 0, count = 0.
